// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams,
// with optional packet locking and a busy-rise timeout guard.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PKT_LOCK     = 1,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_q, last_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic [IW:0]   sum;
  logic [IW-1:0] acc_idx;
  logic          accept;
  logic [IW-1:0] ptr_next;

  // First valid requester at or after the round-robin pointer, wrapping mod NUM_REQ.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (!sel_found && req_valid[sum[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    acc_idx   = grant_q;
    if (rstb) begin
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            req_ready[sel_idx] = 1'b1;
            acc_idx            = sel_idx;
          end
        end
        S_LOCKED: req_ready[grant_q] = 1'b1;
        default: ;
      endcase
    end
  end

  assign accept   = |(req_ready & req_valid);
  assign ptr_next = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    grant_d    = grant_q;
    locked_d   = locked_q;
    err_d      = err_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE, S_LOCKED: begin
        if (accept) begin
          tx_data_d  = req_data[8*acc_idx +: 8];
          last_d     = req_last[acc_idx];
          grant_d    = acc_idx;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A busy already high here (stale frame) still counts as the handshake.
        if (tx_busy) begin
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_DRAIN;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          tx_valid_d = 1'b0;
          err_d      = 1'b1;
          locked_d   = 1'b0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          if ((PKT_LOCK != 0) && !last_q) begin
            locked_d = 1'b1;
            state_d  = S_LOCKED;
          end else begin
            locked_d = 1'b0;
            ptr_d    = ptr_next;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      grant_q    <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: instance a uses packet locking, instance b re-arbitrates per byte.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0]  a_valid = '0, a_last = '0, a_ready;
  logic [31:0] a_data = '0;
  logic        a_tx_valid, a_tx_busy, a_locked, a_err;
  logic [7:0]  a_tx_data;
  logic [1:0]  a_grant;
  logic        a_busy_en = 1'b1;
  int          a_busy_cnt = 0;

  logic [3:0]  b_valid = '0, b_last = '0, b_ready;
  logic [31:0] b_data = '0;
  logic        b_tx_valid, b_tx_busy, b_locked, b_err;
  logic [7:0]  b_tx_data;
  logic [1:0]  b_grant;
  int          b_busy_cnt = 0;

  logic [7:0] a_log_d [0:63];
  logic [1:0] a_log_g [0:63];
  int         a_n = 0;
  logic [7:0] b_log_d [0:63];
  logic [1:0] b_log_g [0:63];
  int         b_n = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .PKT_LOCK(1), .BUSY_TIMEOUT(16)) dut_a (
    .clk(clk), .rstb(rstb), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
    .req_ready(a_ready), .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_busy(a_tx_busy),
    .grant_id(a_grant), .locked(a_locked), .err_timeout(a_err));

  uart_tx_arbiter #(.NUM_REQ(4), .PKT_LOCK(0), .BUSY_TIMEOUT(16)) dut_b (
    .clk(clk), .rstb(rstb), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
    .req_ready(b_ready), .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_busy(b_tx_busy),
    .grant_id(b_grant), .locked(b_locked), .err_timeout(b_err));

  // UART models: busy rises the cycle after tx_valid is seen and stays high 10 clk.
  assign a_tx_busy = (a_busy_cnt != 0);
  assign b_tx_busy = (b_busy_cnt != 0);

  always @(posedge clk) begin
    if (a_busy_cnt != 0) a_busy_cnt <= a_busy_cnt - 1;
    else if (a_busy_en && a_tx_valid) a_busy_cnt <= 10;
    if (b_busy_cnt != 0) b_busy_cnt <= b_busy_cnt - 1;
    else if (b_tx_valid) b_busy_cnt <= 10;
  end

  always @(posedge clk) begin
    if (rstb && a_tx_valid && a_tx_busy) begin
      a_log_d[a_n] <= a_tx_data;
      a_log_g[a_n] <= a_grant;
      a_n <= a_n + 1;
    end
    if (rstb && b_tx_valid && b_tx_busy) begin
      b_log_d[b_n] <= b_tx_data;
      b_log_g[b_n] <= b_grant;
      b_n <= b_n + 1;
    end
  end

  task automatic test_reset;
    @(negedge clk);
    total++; if (a_ready !== 4'b0000) begin bad++; $display("FAIL reset_a_ready got=%b want=0000", a_ready); end
    total++; if ({a_tx_valid, a_tx_data, a_grant, a_locked, a_err} !== 13'd0) begin
      bad++; $display("FAIL reset_a_outs got=%b%h%h%b%b want=all zero", a_tx_valid, a_tx_data, a_grant, a_locked, a_err); end
    total++; if ({b_ready, b_tx_valid, b_tx_data, b_grant, b_locked, b_err} !== 17'd0) begin
      bad++; $display("FAIL reset_b_outs got=%b%b%h%h%b%b want=all zero", b_ready, b_tx_valid, b_tx_data, b_grant, b_locked, b_err); end
    rstb = 1'b1;
  endtask

  task automatic test_single;
    int n;
    int tv_fall;
    logic hold_bad;
    @(negedge clk);
    a_valid = 4'b0100; a_data[23:16] = 8'h5A; a_last[2] = 1'b1;
    #1;
    total++; if (a_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", a_ready); end
    @(posedge clk); @(negedge clk);
    a_valid = 4'b0001; a_data[23:16] = 8'hFF; a_data[7:0] = 8'h01; a_last[0] = 1'b1;
    #1;
    total++; if (a_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_pulse got=%b want=0000", a_ready); end
    total++; if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h5A) begin
      bad++; $display("FAIL single_issue got=%b/%h want=1/5a", a_tx_valid, a_tx_data); end
    total++; if (a_grant !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d want=2", a_grant); end
    n = 0; tv_fall = -1; hold_bad = 1'b0;
    while (a_ready == 4'b0000 && n < 40) begin
      if (!a_tx_valid && tv_fall < 0) tv_fall = n;
      if (a_tx_data !== 8'h5A) hold_bad = 1'b1;
      @(negedge clk); #1; n++;
    end
    total++; if (tv_fall != 2) begin bad++; $display("FAIL single_txvalid_fall got=%0d want=2", tv_fall); end
    total++; if (hold_bad) begin bad++; $display("FAIL single_data_hold got=changed want=5a held"); end
    total++; if (n != 12) begin bad++; $display("FAIL single_free_cycle got=%0d want=12", n); end
    total++; if (a_ready !== 4'b0001) begin bad++; $display("FAIL single_next_ready got=%b want=0001", a_ready); end
    a_valid = 4'b0000;
    total++; if (a_n != 1 || a_log_d[0] !== 8'h5A || a_log_g[0] !== 2'd2) begin
      bad++; $display("FAIL single_log got=%0d/%h/%0d want=1/5a/2", a_n, a_log_d[0], a_log_g[0]); end
  endtask

  task automatic test_rr;
    int k;
    logic [7:0] exp_d [0:4];
    logic [1:0] exp_g [0:4];
    exp_d = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB0};
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    @(negedge clk);
    b_data = 32'hB3B2B1B0; b_last = 4'b1111; b_valid = 4'b1111;
    k = 0;
    while (b_n < 5 && k < 200) begin @(negedge clk); k++; end
    b_valid = 4'b0000;
    total++; if (b_n < 5) begin bad++; $display("FAIL rr_timeout got=%0d want=5 bytes", b_n); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (b_log_d[i] !== exp_d[i] || b_log_g[i] !== exp_g[i]) begin
        bad++; $display("FAIL rr_order[%0d] got=%h/%0d want=%h/%0d", i, b_log_d[i], b_log_g[i], exp_d[i], exp_g[i]);
      end
    end
    total++; if (b_locked !== 1'b0) begin bad++; $display("FAIL rr_locked got=%b want=0", b_locked); end
  endtask

  task automatic test_lock;
    int k;
    int base;
    logic [7:0] exp_d [0:3];
    logic [1:0] exp_g [0:3];
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h0A};
    exp_g = '{2'd1, 2'd1, 2'd1, 2'd0};
    base = a_n;
    @(negedge clk);
    a_valid = 4'b0010; a_data[15:8] = 8'h11; a_last[1] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      k = 0; #1;
      while (!a_ready[1] && k < 60) begin @(negedge clk); #1; k++; end
      total++; if (!a_ready[1]) begin bad++; $display("FAIL lock_wait[%0d] got=%b want=ready[1]", b, a_ready); end
      if (b > 0) begin
        total++; if (a_locked !== 1'b1 || a_ready !== 4'b0010) begin
          bad++; $display("FAIL lock_hold[%0d] got=%b/%b want=1/0010", b, a_locked, a_ready); end
      end
      @(posedge clk); @(negedge clk);
      if (b == 0) begin a_valid[0] = 1'b1; a_data[7:0] = 8'h0A; a_last[0] = 1'b1; end
      if (b == 0) begin a_data[15:8] = 8'h12; a_last[1] = 1'b0; end
      else if (b == 1) begin a_data[15:8] = 8'h13; a_last[1] = 1'b1; end
      else a_valid[1] = 1'b0;
    end
    k = 0; #1;
    while (!a_ready[0] && k < 60) begin @(negedge clk); #1; k++; end
    total++; if (a_ready !== 4'b0001 || a_locked !== 1'b0) begin
      bad++; $display("FAIL lock_release got=%b/%b want=0001/0", a_ready, a_locked); end
    @(posedge clk); @(negedge clk);
    a_valid[0] = 1'b0;
    k = 0;
    while (a_n < base + 4 && k < 60) begin @(negedge clk); k++; end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (a_log_d[base+i] !== exp_d[i] || a_log_g[base+i] !== exp_g[i]) begin
        bad++; $display("FAIL lock_order[%0d] got=%h/%0d want=%h/%0d", i, a_log_d[base+i], a_log_g[base+i], exp_d[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int k;
    int n;
    @(negedge clk);
    a_valid = 4'b1000; a_data[31:24] = 8'h33; a_last[3] = 1'b1;
    k = 0; #1;
    while (!a_ready[3] && k < 60) begin @(negedge clk); #1; k++; end
    total++; if (!a_ready[3]) begin bad++; $display("FAIL to_wait got=%b want=ready[3]", a_ready); end
    a_busy_en = 1'b0;
    @(posedge clk); @(negedge clk);
    a_valid = 4'b0000;
    n = 0;
    while (a_tx_valid && n < 40) begin n++; @(negedge clk); end
    total++; if (n != 16) begin bad++; $display("FAIL to_valid_len got=%0d want=16", n); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", a_err); end
    a_busy_en = 1'b1;
    a_valid = 4'b0100; a_data[23:16] = 8'h22; a_last[2] = 1'b1;
    #1;
    total++; if (a_ready !== 4'b0100) begin bad++; $display("FAIL to_next_ready got=%b want=0100", a_ready); end
    @(posedge clk); @(negedge clk);
    a_valid = 4'b0000;
    k = 0;
    while (!a_tx_busy && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    total++; if (a_log_d[a_n-1] !== 8'h22 || a_err !== 1'b1) begin
      bad++; $display("FAIL to_serve got=%h/%b want=22/1", a_log_d[a_n-1], a_err); end
  endtask

  task automatic test_reset_mid;
    int k;
    int base;
    // Instance a is now in DRAIN for byte 0x22 with busy high.
    a_valid = 4'b0100; a_data[23:16] = 8'h44; a_last[2] = 1'b1;
    rstb = 1'b0;
    #1;
    total++; if ({a_ready, a_tx_valid, a_tx_data, a_grant, a_locked, a_err} !== 17'd0) begin
      bad++; $display("FAIL rst_mid_outs got=%b%b%h%h%b%b want=all zero", a_ready, a_tx_valid, a_tx_data, a_grant, a_locked, a_err); end
    @(negedge clk);
    rstb = 1'b1;
    #1;
    total++; if (a_ready !== 4'b0100) begin bad++; $display("FAIL rst_mid_ready got=%b want=0100", a_ready); end
    base = a_n;
    @(posedge clk); @(negedge clk);
    a_valid = 4'b0000;
    total++; if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h44 || a_grant !== 2'd2) begin
      bad++; $display("FAIL rst_mid_issue got=%b/%h/%0d want=1/44/2", a_tx_valid, a_tx_data, a_grant); end
    k = 0;
    while (a_n == base && k < 40) begin @(negedge clk); k++; end
    total++; if (a_n == base || a_log_d[base] !== 8'h44) begin
      bad++; $display("FAIL rst_mid_send got=%0d/%h want=%0d/44", a_n, a_log_d[base], base + 1); end
    repeat (15) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_lock();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
